// File: rtl/ctrl_decode_pipe_if.sv
// Handshake and control-bundle bus between fetch and the registered decoder.
// Carries the instruction input channel and the decoded output channel.
// slave = decoder side, master = driver/consumer side.
interface ctrl_decode_pipe_if #(
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 16
);
    logic                in_valid_i;
    logic                in_ready_o;
    logic [31:0]         instr_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic                RegWrite_o;
    logic                ALUSrc_o;
    logic                RegDst_o;
    logic                Branch_o;
    logic                BranchNe_o;
    logic                MemRead_o;
    logic                MemWrite_o;
    logic                MemToReg_o;
    logic                Jump_o;
    logic                ExtZero_o;
    logic [ALU_OP_W-1:0] ALU_op_o;
    logic [4:0]          rs_o;
    logic [4:0]          rt_o;
    logic [4:0]          rd_o;
    logic                bubble_o;
    logic                illegal_o;
    logic [CNT_W-1:0]    instr_cnt_o;
    logic [CNT_W-1:0]    illegal_cnt_o;

    modport slave (
        input  in_valid_i, instr_i, out_ready_i,
        output in_ready_o, out_valid_o,
               RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, BranchNe_o,
               MemRead_o, MemWrite_o, MemToReg_o, Jump_o, ExtZero_o,
               ALU_op_o, rs_o, rt_o, rd_o, bubble_o, illegal_o,
               instr_cnt_o, illegal_cnt_o
    );

    modport master (
        output in_valid_i, instr_i, out_ready_i,
        input  in_ready_o, out_valid_o,
               RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, BranchNe_o,
               MemRead_o, MemWrite_o, MemToReg_o, Jump_o, ExtZero_o,
               ALU_op_o, rs_o, rt_o, rd_o, bubble_o, illegal_o,
               instr_cnt_o, illegal_cnt_o
    );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// Registered main-control decoder with load-use bubble insertion and activity counters.
// Latency: 1 cycle from accept to out_valid_o.
// Backpressure: in_ready_o drops while the output slot is held or a load-use hazard is pending.
module ctrl_decode_pipe #(
    parameter int ALU_OP_W  = 3,
    parameter int CNT_W     = 16,
    parameter int HAZARD_EN = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ctrl_decode_pipe_if.slave  bus
);
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic       branch_ne;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       jump;
        logic       ext_zero;
        logic [2:0] alu_op;
    } ctrl_t;

    logic [5:0]       opcode;
    logic [4:0]       rs, rt, rd;
    ctrl_t            ctrl_d, ctrl_q;
    logic             illegal_d, illegal_q;
    logic             rs_src, rt_src;
    logic             bubble_q, out_valid_q;
    logic             pend_q;
    logic [4:0]       pend_rt_q;
    logic [4:0]       rs_q, rt_q, rd_q;
    logic [CNT_W-1:0] instr_cnt_q, illegal_cnt_q;
    logic             hazard, slot_free, accept;
    logic             unused_low_bits;

    assign opcode = bus.instr_i[31:26];
    assign rs     = bus.instr_i[25:21];
    assign rt     = bus.instr_i[20:16];
    assign rd     = bus.instr_i[15:11];
    // shamt/funct/immediate bits do not influence main control
    assign unused_low_bits = ^bus.instr_i[10:0];

    // Opcode decode into the control bundle plus which register fields are read as sources
    always_comb begin
        ctrl_d    = '0;
        illegal_d = 1'b0;
        rs_src    = 1'b1;
        rt_src    = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl_d.alu_op = 3'b010; ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1;
                rt_src = 1'b1;
            end
            OP_LW: begin
                ctrl_d.alu_src = 1'b1; ctrl_d.reg_write = 1'b1;
                ctrl_d.mem_read = 1'b1; ctrl_d.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl_d.alu_src = 1'b1; ctrl_d.mem_write = 1'b1;
                rt_src = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d.alu_op = 3'b001; ctrl_d.branch = 1'b1;
                rt_src = 1'b1;
            end
            OP_BNE: begin
                ctrl_d.alu_op = 3'b001; ctrl_d.branch = 1'b1; ctrl_d.branch_ne = 1'b1;
                rt_src = 1'b1;
            end
            OP_ADDI: begin
                ctrl_d.alu_op = 3'b011; ctrl_d.alu_src = 1'b1; ctrl_d.reg_write = 1'b1;
            end
            OP_SLTIU: begin
                ctrl_d.alu_op = 3'b100; ctrl_d.alu_src = 1'b1; ctrl_d.reg_write = 1'b1;
            end
            OP_LUI: begin
                ctrl_d.alu_op = 3'b101; ctrl_d.alu_src = 1'b1; ctrl_d.reg_write = 1'b1;
                rs_src = 1'b0;
            end
            OP_ORI: begin
                ctrl_d.alu_op = 3'b110; ctrl_d.alu_src = 1'b1; ctrl_d.reg_write = 1'b1;
                ctrl_d.ext_zero = 1'b1;
            end
            OP_ANDI: begin
                ctrl_d.alu_op = 3'b111; ctrl_d.alu_src = 1'b1; ctrl_d.reg_write = 1'b1;
                ctrl_d.ext_zero = 1'b1;
            end
            OP_J: begin
                ctrl_d.jump = 1'b1;
                rs_src = 1'b0;
            end
            default: begin
                illegal_d = 1'b1;
                rs_src    = 1'b0;
            end
        endcase
    end

    // A pending load into $zero never stalls; illegal opcodes never stall
    assign hazard = (HAZARD_EN != 0) && pend_q && bus.in_valid_i && (pend_rt_q != 5'd0) &&
                    !illegal_d && ((rs_src && rs == pend_rt_q) || (rt_src && rt == pend_rt_q));
    assign slot_free = !out_valid_q || bus.out_ready_i;
    assign accept    = bus.in_valid_i && slot_free && !hazard;

    // Output slot: load a decoded entry, load a bubble, or drain; counters saturate
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q        <= '0;
            illegal_q     <= 1'b0;
            bubble_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            pend_q        <= 1'b0;
            pend_rt_q     <= 5'd0;
            rs_q          <= 5'd0;
            rt_q          <= 5'd0;
            rd_q          <= 5'd0;
            instr_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else if (accept) begin
            ctrl_q      <= ctrl_d;
            illegal_q   <= illegal_d;
            bubble_q    <= 1'b0;
            out_valid_q <= 1'b1;
            rs_q        <= rs;
            rt_q        <= rt;
            rd_q        <= rd;
            pend_q      <= (opcode == OP_LW);
            pend_rt_q   <= rt;
            if (instr_cnt_q != '1)
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            if (illegal_d && illegal_cnt_q != '1)
                illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
        end else if (hazard && slot_free) begin
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
            bubble_q    <= 1'b1;
            out_valid_q <= 1'b1;
            rs_q        <= 5'd0;
            rt_q        <= 5'd0;
            rd_q        <= 5'd0;
            pend_q      <= 1'b0;
        end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready_o    = slot_free && !hazard;
    assign bus.out_valid_o   = out_valid_q;
    assign bus.RegWrite_o    = ctrl_q.reg_write;
    assign bus.ALUSrc_o      = ctrl_q.alu_src;
    assign bus.RegDst_o      = ctrl_q.reg_dst;
    assign bus.Branch_o      = ctrl_q.branch;
    assign bus.BranchNe_o    = ctrl_q.branch_ne;
    assign bus.MemRead_o     = ctrl_q.mem_read;
    assign bus.MemWrite_o    = ctrl_q.mem_write;
    assign bus.MemToReg_o    = ctrl_q.mem_to_reg;
    assign bus.Jump_o        = ctrl_q.jump;
    assign bus.ExtZero_o     = ctrl_q.ext_zero;
    assign bus.ALU_op_o      = ALU_OP_W'(ctrl_q.alu_op);
    assign bus.rs_o          = rs_q;
    assign bus.rt_o          = rt_q;
    assign bus.rd_o          = rd_q;
    assign bus.bubble_o      = bubble_q;
    assign bus.illegal_o     = illegal_q;
    assign bus.instr_cnt_o   = instr_cnt_q;
    assign bus.illegal_cnt_o = illegal_cnt_q;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: default, no-hazard and 2-bit-counter instances.
// Inputs change on the falling edge; registered outputs are checked on the falling edge.
// Combinational in_ready_o is checked 1ns after inputs change.
module tb_ctrl_decode_pipe;
    localparam logic [31:0] I_ADDI    = 32'h21090005; // addi $t1,$t0,5
    localparam logic [31:0] I_BEQ     = 32'h11090004; // beq  $t0,$t1,4
    localparam logic [31:0] I_LW      = 32'h8E080000; // lw   $t0,0($s0)
    localparam logic [31:0] I_ADD     = 32'h01095020; // add  $t2,$t0,$t1
    localparam logic [31:0] I_LW_ZERO = 32'h8E000000; // lw   $zero,0($s0)
    localparam logic [31:0] I_ADD_Z   = 32'h00005020; // add  $t2,$zero,$zero
    localparam logic [31:0] I_LUI_T0  = 32'h3D081234; // lui  $t0 with rs field = 8
    localparam logic [31:0] I_ILL     = 32'hFC000000; // opcode 111111

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ctrl_decode_pipe_if                b0 ();
    ctrl_decode_pipe_if                b1 ();
    ctrl_decode_pipe_if #(.CNT_W(2))   b2 ();

    ctrl_decode_pipe                                u0 (.clk_i(clk), .rst_i(rst), .bus(b0));
    ctrl_decode_pipe #(.HAZARD_EN(0))               u1 (.clk_i(clk), .rst_i(rst), .bus(b1));
    ctrl_decode_pipe #(.CNT_W(2))                   u2 (.clk_i(clk), .rst_i(rst), .bus(b2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        b0.in_valid_i = 1'b0; b0.instr_i = '0; b0.out_ready_i = 1'b1;
        b1.in_valid_i = 1'b0; b1.instr_i = '0; b1.out_ready_i = 1'b1;
        b2.in_valid_i = 1'b0; b2.instr_i = '0; b2.out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", b0.out_valid_o, 0);
        chk("rst_in_ready", b0.in_ready_o, 1);
        chk("rst_instr_cnt", b0.instr_cnt_o, 0);
        chk("rst_illegal_cnt", b0.illegal_cnt_o, 0);
        chk("rst_regwrite", b0.RegWrite_o, 0);
        chk("rst_bubble", b0.bubble_o, 0);

        // addi: one cycle to out_valid
        @(negedge clk);
        b0.in_valid_i = 1'b1; b0.instr_i = I_ADDI;
        @(negedge clk);
        b0.in_valid_i = 1'b0;
        chk("addi_valid", b0.out_valid_o, 1);
        chk("addi_aluop", b0.ALU_op_o, 3'b011);
        chk("addi_alusrc", b0.ALUSrc_o, 1);
        chk("addi_regwrite", b0.RegWrite_o, 1);
        chk("addi_regdst", b0.RegDst_o, 0);
        chk("addi_rs", b0.rs_o, 8);
        chk("addi_rt", b0.rt_o, 9);
        chk("addi_cnt", b0.instr_cnt_o, 1);
        @(negedge clk);
        chk("drain_valid", b0.out_valid_o, 0);

        // back-pressure holding a beq entry
        b0.in_valid_i = 1'b1; b0.instr_i = I_BEQ; b0.out_ready_i = 1'b0;
        @(negedge clk);
        b0.instr_i = I_ADDI;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", b0.out_valid_o, 1);
            chk("bp_branch", b0.Branch_o, 1);
            chk("bp_aluop", b0.ALU_op_o, 3'b001);
            chk("bp_rt", b0.rt_o, 9);
            chk("bp_in_ready", b0.in_ready_o, 0);
            chk("bp_cnt", b0.instr_cnt_o, 2);
            @(negedge clk);
        end
        b0.out_ready_i = 1'b1;
        #1;
        chk("release_in_ready", b0.in_ready_o, 1);
        @(negedge clk);
        chk("release_aluop", b0.ALU_op_o, 3'b011);
        chk("release_branch", b0.Branch_o, 0);
        chk("release_cnt", b0.instr_cnt_o, 3);

        // lw then dependent add: one bubble
        b0.instr_i = I_LW;
        @(negedge clk);
        chk("lw_memread", b0.MemRead_o, 1);
        chk("lw_memtoreg", b0.MemToReg_o, 1);
        chk("lw_cnt", b0.instr_cnt_o, 4);
        b0.instr_i = I_ADD;
        #1;
        chk("hz_in_ready", b0.in_ready_o, 0);
        @(negedge clk);
        chk("bub_valid", b0.out_valid_o, 1);
        chk("bub_flag", b0.bubble_o, 1);
        chk("bub_regwrite", b0.RegWrite_o, 0);
        chk("bub_rs", b0.rs_o, 0);
        chk("bub_cnt", b0.instr_cnt_o, 4);
        @(negedge clk);
        chk("add_bubble", b0.bubble_o, 0);
        chk("add_aluop", b0.ALU_op_o, 3'b010);
        chk("add_regdst", b0.RegDst_o, 1);
        chk("add_rd", b0.rd_o, 10);
        chk("add_cnt", b0.instr_cnt_o, 5);

        // lw $zero then add of $zero: no stall
        b0.instr_i = I_LW_ZERO;
        @(negedge clk);
        b0.instr_i = I_ADD_Z;
        #1;
        chk("zero_in_ready", b0.in_ready_o, 1);
        @(negedge clk);
        chk("zero_bubble", b0.bubble_o, 0);
        chk("zero_regdst", b0.RegDst_o, 1);
        chk("zero_cnt", b0.instr_cnt_o, 7);

        // lw $t0 then lui $t0 (rs field matches but is not a source)
        b0.instr_i = I_LW;
        @(negedge clk);
        b0.instr_i = I_LUI_T0;
        #1;
        chk("lui_in_ready", b0.in_ready_o, 1);
        @(negedge clk);
        chk("lui_aluop", b0.ALU_op_o, 3'b101);
        chk("lui_bubble", b0.bubble_o, 0);
        chk("lui_cnt", b0.instr_cnt_o, 9);

        // illegal opcode
        b0.instr_i = I_ILL;
        @(negedge clk);
        b0.in_valid_i = 1'b0;
        chk("ill_flag", b0.illegal_o, 1);
        chk("ill_regwrite", b0.RegWrite_o, 0);
        chk("ill_aluop", b0.ALU_op_o, 0);
        chk("ill_alusrc", b0.ALUSrc_o, 0);
        chk("ill_jump", b0.Jump_o, 0);
        chk("ill_cnt", b0.illegal_cnt_o, 1);
        chk("ill_instr_cnt", b0.instr_cnt_o, 10);

        // pending load survives idle cycles
        b0.in_valid_i = 1'b1; b0.instr_i = I_LW;
        @(negedge clk);
        b0.in_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        b0.in_valid_i = 1'b1; b0.instr_i = I_ADD;
        #1;
        chk("idle_hz_in_ready", b0.in_ready_o, 0);
        @(negedge clk);
        chk("idle_bubble", b0.bubble_o, 1);
        @(negedge clk);
        b0.in_valid_i = 1'b0;
        chk("idle_add_bubble", b0.bubble_o, 0);
        chk("idle_add_regdst", b0.RegDst_o, 1);
        chk("idle_add_cnt", b0.instr_cnt_o, 12);

        // hazard insertion disabled
        b1.in_valid_i = 1'b1; b1.instr_i = I_LW;
        @(negedge clk);
        b1.instr_i = I_ADD;
        #1;
        chk("nohz_in_ready", b1.in_ready_o, 1);
        @(negedge clk);
        b1.in_valid_i = 1'b0;
        chk("nohz_bubble", b1.bubble_o, 0);
        chk("nohz_regdst", b1.RegDst_o, 1);
        chk("nohz_cnt", b1.instr_cnt_o, 2);

        // 2-bit counter saturation, then reset with a held entry
        b2.in_valid_i = 1'b1; b2.instr_i = I_ADDI;
        repeat (5) @(negedge clk);
        b2.in_valid_i = 1'b0; b2.out_ready_i = 1'b0;
        chk("sat_cnt", b2.instr_cnt_o, 3);
        chk("sat_valid", b2.out_valid_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst2_valid", b2.out_valid_o, 0);
        chk("rst2_cnt", b2.instr_cnt_o, 0);
        chk("rst2_ill_cnt", b2.illegal_cnt_o, 0);
        chk("rst2_in_ready", b2.in_ready_o, 1);
        chk("rst2_b0_cnt", b0.instr_cnt_o, 0);
        chk("rst2_b0_ill_cnt", b0.illegal_cnt_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
